dz_rbuf: RTL and testbench

- DZ11 receiver scanner and silo, 64 entries.
- Polls the eight UART receivers and timestamps nothing. Each received character is packed with its line number and error flags, then pushed into the silo FIFO.
- Presents the head entry as the RBUF register.
- Produces rbufRDONE and rbufSA, which the DZ11 CSR block consumes.

---
 rtl/dz_rbuf_pkg.sv | 37 +++
 rtl/dz_silo.sv | 74 +++++++
 rtl/dz_rbuf.sv | 166 ++++++++++++++++
 tb/tb_dz_rbuf.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dz_rbuf_pkg.sv
// dz_rbuf_pkg -- shared definitions for the DZ11 receiver silo.
//   DZ_DEPTH_DEF / DZ_ALARM_DEF : default silo depth and alarm threshold
//   dz_entry_t                  : RBUF / silo entry layout
//   dz_pack()                   : builds a valid entry from a received character
package dz_rbuf_pkg;

    localparam int DZ_DEPTH_DEF = 64;
    localparam int DZ_ALARM_DEF = 16;

    // Silo entry, identical to the RBUF register image.
    typedef struct packed {
        logic       dval;   // [15] data valid
        logic       ovre;   // [14] characters were lost before this one
        logic       frme;   // [13] framing error
        logic       pare;   // [12] parity error
        logic       rsvd;   // [11] reads as zero
        logic [2:0] line;   // [10:8] receiving line
        logic [7:0] ch;     // [7:0] character
    } dz_entry_t;

    function automatic dz_entry_t dz_pack(input logic       ovr,
                                          input logic       fe,
                                          input logic       pe,
                                          input logic [2:0] line,
                                          input logic [7:0] ch);
        dz_entry_t e;
        e.dval = 1'b1;
        e.ovre = ovr;
        e.frme = fe;
        e.pare = pe;
        e.rsvd = 1'b0;
        e.line = line;
        e.ch   = ch;
        return e;
    endfunction

endpackage

// File: rtl/dz_silo.sv
// dz_silo -- synchronous FIFO holding received-character entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_srst     : synchronous clear (empties the FIFO)
//   i_wr/i_wdata : push request and entry
//   i_rd       : pop request (ignored when empty)
//   o_full/o_empty/o_count : occupancy status
//   o_head     : combinational view of the oldest entry
// A push while full is accepted only when a pop happens in the same cycle.
module dz_silo
    import dz_rbuf_pkg::*;
#(
    parameter int DEPTH = DZ_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_srst,
    input  logic                     i_wr,
    input  dz_entry_t                i_wdata,
    input  logic                     i_rd,
    output logic                     o_full,
    output logic                     o_empty,
    output dz_entry_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    dz_entry_t          r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               w_rd_ok;
    logic               w_wr_ok;

    assign o_empty = (r_count == (AW+1)'(0));
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_rd_ok = i_rd & ~o_empty;
    assign w_wr_ok = i_wr & (~o_full | w_rd_ok);

    // Entry storage; no reset needed since o_empty masks stale data.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dz_rbuf.sv
// dz_rbuf -- DZ11 receiver scanner, overrun tracking, silo alarm and RBUF.
//   clk, rst        : clock, asynchronous active-low reset
//   devRESET/csrCLR : synchronous clear of all state
//   csrMSE/csrSAE   : scan enable, silo alarm enable
//   rbufREAD        : RBUF read cycle; the entry is popped when it ends
//   uartRX*         : per-line receiver status/data; uartRXCLR acknowledges
//   regRBUF         : head entry with DVAL, zero when the silo is empty
//   rbufRDONE/rbufSA: receiver done and silo alarm (registered)
module dz_rbuf
    import dz_rbuf_pkg::*;
#(
    parameter int DEPTH = DZ_DEPTH_DEF,
    parameter int ALARM = DZ_ALARM_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        devRESET,
    input  logic        csrCLR,
    input  logic        csrMSE,
    input  logic        csrSAE,
    input  logic        rbufREAD,
    input  logic [7:0]  uartRXFULL,
    input  logic [63:0] uartRXDATA,
    input  logic [7:0]  uartRXFRME,
    input  logic [7:0]  uartRXPARE,
    output logic [7:0]  uartRXCLR,
    output logic [15:0] regRBUF,
    output logic        rbufRDONE,
    output logic        rbufSA
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(ALARM + 1);
    localparam logic [AW-1:0] ALARM_V = AW'(ALARM);

    logic [2:0]     r_scan;
    logic           r_ovr;
    logic [AW-1:0]  r_acnt;
    logic           r_sa;
    logic           r_rdone;
    logic           r_read_d;

    logic           w_sclr;
    logic           w_hit;
    logic           w_pop_edge;
    logic           w_rd;
    logic           w_wr;
    logic           w_drop;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_occ_next;
    logic [AW-1:0]  w_acnt_next;
    logic           w_sa_next;
    logic           w_rdone_next;
    logic [7:0]     w_ack;
    dz_entry_t      w_head;
    dz_entry_t      w_entry;
    dz_entry_t      w_rbuf;

    assign w_sclr     = devRESET | csrCLR;
    assign w_hit      = rst & csrMSE & ~w_sclr & uartRXFULL[r_scan];
    assign w_pop_edge = r_read_d & ~rbufREAD & ~w_sclr;
    assign w_rd       = w_pop_edge & ~w_empty;
    // A same-cycle pop frees the slot, so a full silo still accepts.
    assign w_wr       = w_hit & (~w_full | w_rd);
    assign w_drop     = w_hit & ~w_wr;
    assign w_entry    = dz_pack(r_ovr, uartRXFRME[r_scan], uartRXPARE[r_scan],
                                r_scan, uartRXDATA[{r_scan, 3'b000} +: 8]);
    assign w_occ_next = w_count + {{(CW-1){1'b0}}, w_wr} - {{(CW-1){1'b0}}, w_rd};

    dz_silo #(.DEPTH(DEPTH)) u_silo (
        .clk     (clk),
        .rst_n   (rst),
        .i_srst  (w_sclr),
        .i_wr    (w_wr),
        .i_wdata (w_entry),
        .i_rd    (w_rd),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // One-hot acknowledge of the line being scanned.
    always_comb begin
        w_ack = 8'h00;
        if (w_hit) begin
            w_ack[r_scan] = 1'b1;
        end else begin
            w_ack = 8'h00;
        end
    end

    // RBUF image: head with DVAL forced, all zero when empty.
    always_comb begin
        w_rbuf = 16'h0000;
        if (!w_empty) begin
            w_rbuf      = w_head;
            w_rbuf.dval = 1'b1;
        end else begin
            w_rbuf = 16'h0000;
        end
    end

    // Alarm count: pop clears first, then a same-cycle store counts as one.
    always_comb begin
        w_acnt_next = r_acnt;
        if (w_pop_edge) begin
            w_acnt_next = {{(AW-1){1'b0}}, w_wr};
        end else if (w_wr && (r_acnt != ALARM_V)) begin
            w_acnt_next = r_acnt + AW'(1);
        end else begin
            w_acnt_next = r_acnt;
        end
    end

    // Status flags are registered from next-state values so they line up with the silo.
    always_comb begin
        w_sa_next    = csrSAE & (w_acnt_next == ALARM_V);
        w_rdone_next = 1'b0;
        if (csrSAE) begin
            w_rdone_next = w_sa_next;
        end else begin
            w_rdone_next = (w_occ_next != {CW{1'b0}});
        end
    end

    // Scanner, overrun, alarm and read-edge state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan   <= 3'd0;
            r_ovr    <= 1'b0;
            r_acnt   <= '0;
            r_sa     <= 1'b0;
            r_rdone  <= 1'b0;
            r_read_d <= 1'b0;
        end else if (w_sclr) begin
            r_scan   <= 3'd0;
            r_ovr    <= 1'b0;
            r_acnt   <= '0;
            r_sa     <= 1'b0;
            r_rdone  <= 1'b0;
            r_read_d <= 1'b0;
        end else begin
            r_scan   <= csrMSE ? (r_scan + 3'd1) : r_scan;
            if (w_wr) begin
                r_ovr <= 1'b0;
            end else if (w_drop) begin
                r_ovr <= 1'b1;
            end else begin
                r_ovr <= r_ovr;
            end
            r_acnt   <= w_acnt_next;
            r_sa     <= w_sa_next;
            r_rdone  <= w_rdone_next;
            r_read_d <= rbufREAD;
        end
    end

    assign uartRXCLR = w_ack;
    assign regRBUF   = w_rbuf;
    assign rbufRDONE = r_rdone;
    assign rbufSA    = r_sa;

endmodule

// File: tb/tb_dz_rbuf.sv
module tb_dz_rbuf;

    localparam int DEPTH = 64;
    localparam int ALARM = 16;

    logic        clk = 1'b0;
    logic        rst, devRESET, csrCLR, csrMSE, csrSAE, rbufREAD;
    logic [7:0]  uartRXFULL, uartRXFRME, uartRXPARE, uartRXCLR;
    logic [63:0] uartRXDATA;
    logic [15:0] regRBUF;
    logic        rbufRDONE, rbufSA;

    always #5 clk = ~clk;

    dz_rbuf dut (
        .clk(clk), .rst(rst), .devRESET(devRESET), .csrCLR(csrCLR),
        .csrMSE(csrMSE), .csrSAE(csrSAE), .rbufREAD(rbufREAD),
        .uartRXFULL(uartRXFULL), .uartRXDATA(uartRXDATA),
        .uartRXFRME(uartRXFRME), .uartRXPARE(uartRXPARE),
        .uartRXCLR(uartRXCLR), .regRBUF(regRBUF),
        .rbufRDONE(rbufRDONE), .rbufSA(rbufSA)
    );

    // Reference model: silo as a queue plus a few counters.
    logic [15:0] mq[$];
    bit          m_ovr, m_sa, m_rdone, m_read_d;
    int          m_acnt, m_scan;
    // UART side: per-line pending character.
    bit          u_full[8];
    logic [7:0]  u_data[8];
    bit          u_fe[8], u_pe[8];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_uart();
        for (int i = 0; i < 8; i++) begin
            uartRXFULL[i]           = u_full[i];
            uartRXFRME[i]           = u_fe[i];
            uartRXPARE[i]           = u_pe[i];
            uartRXDATA[8*i +: 8]    = u_data[i];
        end
    endtask

    // One clock: compare at negedge, advance the model to the next posedge.
    task automatic step();
        logic [7:0]  eack;
        logic [15:0] erbuf, ent;
        logic [2:0]  ln;
        bit          pop, wrote;
        drive_uart();
        @(negedge clk);
        eack = 8'h00;
        if (rst && !devRESET && !csrCLR && csrMSE && u_full[m_scan]) eack[m_scan] = 1'b1;
        erbuf = (mq.size() != 0) ? mq[0] : 16'h0000;
        chk("rxclr", 16'(uartRXCLR), 16'(eack));
        chk("rbuf",  regRBUF, erbuf);
        chk("rdone", 16'(rbufRDONE), 16'(m_rdone));
        chk("sa",    16'(rbufSA), 16'(m_sa));
        if (!rst || devRESET || csrCLR) begin
            mq.delete();
            m_ovr = 1'b0; m_sa = 1'b0; m_rdone = 1'b0; m_read_d = 1'b0;
            m_acnt = 0; m_scan = 0;
        end else begin
            pop   = m_read_d && !rbufREAD;
            wrote = 1'b0;
            if (pop && mq.size() != 0) ent = mq.pop_front();
            if (eack != 8'h00) begin
                ln = m_scan[2:0];
                if (mq.size() < DEPTH) begin
                    mq.push_back({1'b1, m_ovr, u_fe[m_scan], u_pe[m_scan], 1'b0, ln, u_data[m_scan]});
                    m_ovr = 1'b0;
                    wrote = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                u_full[m_scan] = 1'b0;
            end
            if (pop) m_acnt = 0;
            if (wrote && m_acnt < ALARM) m_acnt++;
            m_sa     = csrSAE && (m_acnt == ALARM);
            m_rdone  = csrSAE ? m_sa : (mq.size() != 0);
            m_read_d = rbufREAD;
            if (csrMSE) m_scan = (m_scan + 1) % 8;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int line, input logic [7:0] d, input bit fe, input bit pe);
        u_full[line] = 1'b1; u_data[line] = d; u_fe[line] = fe; u_pe[line] = pe;
        for (int n = 0; n < 20 && u_full[line]; n++) step();
        total++;
        if (u_full[line]) begin
            bad++;
            $display("FAIL send_timeout: line %0d still pending, required acknowledge", line);
            u_full[line] = 1'b0;
        end
    endtask

    task automatic read_one(output logic [15:0] v);
        v = regRBUF;
        rbufREAD = 1'b1;
        step();
        step();
        rbufREAD = 1'b0;
        step();
    endtask

    task automatic drain(output logic [15:0] last);
        logic [15:0] v;
        last = 16'h0000;
        for (int n = 0; n < 2*DEPTH && mq.size() != 0; n++) begin
            read_one(v);
            last = v;
        end
        chk("drain_empty", 16'(mq.size()), 16'h0000);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        rst = 1'b0; devRESET = 1'b0; csrCLR = 1'b0; csrMSE = 1'b0;
        csrSAE = 1'b0; rbufREAD = 1'b0;
        for (int i = 0; i < 8; i++) begin
            u_full[i] = 1'b0; u_data[i] = 8'h00; u_fe[i] = 1'b0; u_pe[i] = 1'b0;
        end
        u_full[2] = 1'b1;
        m_scan = 0; m_acnt = 0;
        drive_uart();

        // Reset and idle with line 2 pending but scanning disabled.
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("idle_rbuf",  regRBUF, 16'h0000);
        chk("idle_rxclr", 16'(uartRXCLR), 16'h0000);
        chk("idle_rdone", 16'(rbufRDONE), 16'h0000);
        u_full[2] = 1'b0;

        // Single character on line 5 with parity error.
        csrMSE = 1'b1;
        send(5, 8'h41, 1'b0, 1'b1);
        chk("single_rbuf",  regRBUF, 16'h9541);
        chk("single_rdone", 16'(rbufRDONE), 16'h0001);
        rbufREAD = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rbufREAD = 1'b0;
        step();
        chk("single_pop_rbuf",  regRBUF, 16'h0000);
        chk("single_pop_rdone", 16'(rbufRDONE), 16'h0000);

        // Overrun: 64 stored, 65th dropped, one read, 66th carries OVRE.
        for (int k = 0; k < DEPTH; k++)
            send(k % 8, 8'($urandom), 1'($urandom), 1'($urandom));
        send(2, 8'h55, 1'b0, 1'b0);
        chk("ovr_model_occ", 16'(mq.size()), 16'd64);
        read_one(v);
        send(3, 8'h66, 1'b0, 1'b0);
        drain(v);
        chk("ovr_last_entry", v, 16'hC366);

        // Silo alarm at 16 characters since the last read.
        csrSAE = 1'b1;
        step();
        for (int k = 0; k < ALARM - 1; k++) send(k % 8, 8'($urandom), 1'b0, 1'b0);
        chk("alarm15_sa",    16'(rbufSA), 16'h0000);
        chk("alarm15_rdone", 16'(rbufRDONE), 16'h0000);
        send(7, 8'hA5, 1'b0, 1'b0);
        chk("alarm16_sa",    16'(rbufSA), 16'h0001);
        chk("alarm16_rdone", 16'(rbufRDONE), 16'h0001);
        read_one(v);
        chk("alarm_pop_sa",    16'(rbufSA), 16'h0000);
        chk("alarm_pop_rdone", 16'(rbufRDONE), 16'h0000);
        for (int k = 0; k < ALARM - 1; k++) send(k % 8, 8'($urandom), 1'b0, 1'b0);
        chk("alarm_restart15_sa", 16'(rbufSA), 16'h0000);
        send(1, 8'h3C, 1'b0, 1'b0);
        chk("alarm_restart16_sa", 16'(rbufSA), 16'h0001);
        drain(v);
        csrSAE = 1'b0;
        step();

        // Full silo: pop edge coincides with a line 0 enqueue.
        for (int k = 0; k < DEPTH; k++) send(k % 8, 8'($urandom), 1'b0, 1'b0);
        for (int n = 0; n < 10 && m_scan != 0; n++) step();
        csrMSE = 1'b0;
        rbufREAD = 1'b1;
        step();
        step();
        u_full[0] = 1'b1; u_data[0] = 8'h77; u_fe[0] = 1'b0; u_pe[0] = 1'b0;
        rbufREAD = 1'b0;
        csrMSE = 1'b1;
        step();
        chk("simul_model_occ", 16'(mq.size()), 16'd64);
        chk("simul_acked", 16'(u_full[0]), 16'h0000);
        drain(v);
        chk("simul_last_entry", v, 16'h8077);

        // Mid-operation clear with 10 entries held.
        for (int k = 0; k < 10; k++) send(k % 8, 8'($urandom), 1'b0, 1'b0);
        csrCLR = 1'b1;
        step();
        csrCLR = 1'b0;
        chk("clr_rbuf",  regRBUF, 16'h0000);
        chk("clr_rdone", 16'(rbufRDONE), 16'h0000);
        chk("clr_sa",    16'(rbufSA), 16'h0000);
        for (int i = 0; i < 8; i++) begin
            u_full[i] = 1'b1; u_data[i] = 8'($urandom); u_fe[i] = 1'b0; u_pe[i] = 1'b0;
        end
        step();
        v = regRBUF;
        chk("clr_scan_line0", {13'h0, v[10:8]}, 16'h0000);
        for (int i = 0; i < 8; i++) step();
        drain(v);

        // Randomized traffic: arrivals, multi-cycle reads, mode changes, resets.
        for (int c = 0; c < 3000; c++) begin
            int ln;
            ln = int'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0 && !u_full[ln]) begin
                u_full[ln] = 1'b1; u_data[ln] = 8'($urandom);
                u_fe[ln] = 1'($urandom); u_pe[ln] = 1'($urandom);
            end
            if ($urandom_range(0, 3) == 0) rbufREAD = ~rbufREAD;
            if ($urandom_range(0, 99) == 0) csrSAE = ~csrSAE;
            if ($urandom_range(0, 199) == 0) csrMSE = ~csrMSE;
            else if (!csrMSE && $urandom_range(0, 9) == 0) csrMSE = 1'b1;
            devRESET = ($urandom_range(0, 599) == 0);
            csrCLR   = ($urandom_range(0, 799) == 0);
            step();
        end
        devRESET = 1'b0; csrCLR = 1'b0; rbufREAD = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
